// File: rtl/pipe_decode_pkg.sv
// Shared decode constants: RV opcodes, funct fields, ALU operation codes,
// memory access-size codes and the output-slot state type.
package pipe_decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20;

    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b11, SZ_D = 2'b10;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
        ALU_SLTU = 5'd4,  ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
        ALU_OR   = 5'd8,  ALU_AND = 5'd9, ALU_SEQ = 5'd10
    } alu_op_e;

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

    function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt_sub, input logic alt_sra);
        case (f3)
            F3_ADD:  f3_alu = alt_sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  f3_alu = ALU_SLL;
            F3_SLT:  f3_alu = ALU_SLT;
            F3_SLTU: f3_alu = ALU_SLTU;
            F3_XOR:  f3_alu = ALU_XOR;
            F3_SR:   f3_alu = alt_sra ? ALU_SRA : ALU_SRL;
            F3_OR:   f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    endfunction

    function automatic logic [1:0] f3_size(input logic [1:0] f3lo);
        case (f3lo)
            2'b00:   f3_size = SZ_B;
            2'b01:   f3_size = SZ_H;
            2'b10:   f3_size = SZ_W;
            default: f3_size = SZ_D;
        endcase
    endfunction

endpackage

// File: rtl/pipe_decode_if.sv
// Decoded-instruction slot towards execute: valid/ready plus decoded fields.
interface pipe_decode_if #(parameter int XLEN = 32, parameter int ALUOP_L = 5);
    logic               out_valid;
    logic               out_ready;
    logic [6:0]         op;
    logic [ALUOP_L-1:0] alu_op;
    logic [4:0]         rd;
    logic               reg_we;
    logic [XLEN-1:0]    opr1;
    logic [XLEN-1:0]    opr2;
    logic [XLEN-1:0]    val;
    logic               re;
    logic               we;
    logic [1:0]         rlen;
    logic [1:0]         wlen;
    logic               ld_unsigned;
    logic               br_inv;
    logic               illegal;

    modport master (output out_valid, op, alu_op, rd, reg_we, opr1, opr2, val, re, we,
                           rlen, wlen, ld_unsigned, br_inv, illegal,
                    input  out_ready);
    modport slave  (input  out_valid, op, alu_op, rd, reg_we, opr1, opr2, val, re, we,
                           rlen, wlen, ld_unsigned, br_inv, illegal,
                    output out_ready);
endinterface

// File: rtl/pipe_decode_imm_gen.sv
// Immediate extraction for I/S/B/U/J formats, sign-extended to XLEN.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:7]             i_inst,
    output logic signed [XLEN-1:0]  o_imm_i,
    output logic signed [XLEN-1:0]  o_imm_s,
    output logic signed [XLEN-1:0]  o_imm_b,
    output logic signed [XLEN-1:0]  o_imm_u,
    output logic signed [XLEN-1:0]  o_imm_j
);
    assign o_imm_i = XLEN'($signed(i_inst[31:20]));
    assign o_imm_s = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
    assign o_imm_b = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
    assign o_imm_u = XLEN'($signed({i_inst[31:12], 12'b0}));
    assign o_imm_j = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
endmodule

// File: rtl/pipe_decode.sv
// RISC-V decode stage: operand read with writeback bypass, scoreboard
// hazard stall, and a single registered output slot with flush.
module pipe_decode
    import pipe_decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_L = 5,
    parameter int NREG    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_idx,
    output logic [4:0]      rs2_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    pipe_decode_if.master   o_slot
);
    localparam int         SHW    = (XLEN == 64) ? 6 : 5;
    localparam logic [6:0] SRA_HI = (XLEN == 64) ? 7'h10 : 7'h20;

    logic [6:0]  w_opc, w_f7, w_sh_hi;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic signed [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_src1, w_src2, w_shamt, w_opr1, w_opr2, w_val;
    alu_op_e     w_alu;
    logic        w_re, w_we, w_ldu, w_brinv, w_ill, w_writes, w_reg_we, w_use1, w_use2;
    logic [1:0]  w_rlen, w_wlen;
    logic        w_busy1, w_busy2, w_busyd, w_hazard, w_accept;
    slot_e       r_state, w_state_nxt;
    logic [NREG-1:0] r_busy;

    logic [6:0]      r_op;
    alu_op_e         r_alu;
    logic [4:0]      r_rd;
    logic            r_reg_we, r_re, r_we, r_ldu, r_brinv, r_ill;
    logic [XLEN-1:0] r_opr1, r_opr2, r_val;
    logic [1:0]      r_rlen, r_wlen;

    assign w_opc   = in_inst[6:0];
    assign w_rd    = in_inst[11:7];
    assign w_f3    = in_inst[14:12];
    assign w_f7    = in_inst[31:25];
    assign rs1_idx = in_inst[19:15];
    assign rs2_idx = in_inst[24:20];
    assign w_sh_hi = (XLEN == 64) ? {1'b0, in_inst[31:26]} : in_inst[31:25];
    assign w_shamt = {{(XLEN-SHW){1'b0}}, in_inst[20 +: SHW]};

    imm_gen #(.XLEN(XLEN)) u_imm (
        .i_inst  (in_inst[31:7]),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j)
    );

    // A register retiring this cycle is both bypassed and treated as free.
    assign w_src1 = (rs1_idx == 5'd0) ? '0 : (wb_valid && wb_rd == rs1_idx) ? wb_data : rs1_data;
    assign w_src2 = (rs2_idx == 5'd0) ? '0 : (wb_valid && wb_rd == rs2_idx) ? wb_data : rs2_data;
    assign w_busy1 = r_busy[rs1_idx] && !(wb_valid && wb_rd == rs1_idx);
    assign w_busy2 = r_busy[rs2_idx] && !(wb_valid && wb_rd == rs2_idx);
    assign w_busyd = r_busy[w_rd]    && !(wb_valid && wb_rd == w_rd);

    always_comb begin
        w_alu = ALU_ADD; w_opr1 = '0; w_opr2 = '0; w_val = '0;
        w_re = 1'b0; w_we = 1'b0; w_rlen = SZ_B; w_wlen = SZ_B; w_ldu = 1'b0;
        w_brinv = 1'b0; w_ill = 1'b0; w_writes = 1'b0; w_use1 = 1'b0; w_use2 = 1'b0;
        case (w_opc)
            OPC_LUI:   begin w_writes = 1'b1; w_opr2 = w_imm_u; end
            OPC_AUIPC: begin w_writes = 1'b1; w_opr1 = in_pc; w_opr2 = w_imm_u; end
            OPC_JAL: begin
                w_writes = 1'b1; w_opr1 = in_pc; w_opr2 = XLEN'(4); w_val = in_pc + w_imm_j;
            end
            OPC_JALR: begin
                w_writes = 1'b1; w_use1 = 1'b1; w_opr1 = w_src1; w_opr2 = w_imm_i;
                w_val = in_pc + XLEN'(4); w_ill = (w_f3 != 3'd0);
            end
            OPC_OP_IMM: begin
                w_writes = 1'b1; w_use1 = 1'b1; w_opr1 = w_src1; w_opr2 = w_imm_i;
                w_alu = f3_alu(w_f3, 1'b0, in_inst[30]);
                if (w_f3 == F3_SLL || w_f3 == F3_SR) begin
                    w_opr2 = w_shamt;
                    w_ill  = !(w_sh_hi == 7'h00 || (w_f3 == F3_SR && w_sh_hi == SRA_HI));
                end
            end
            OPC_OP: begin
                w_writes = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_opr1 = w_src1; w_opr2 = w_src2;
                w_alu = f3_alu(w_f3, w_f7[5], w_f7[5]);
                w_ill = !(w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == F3_ADD || w_f3 == F3_SR)));
            end
            OPC_LOAD: begin
                w_writes = 1'b1; w_use1 = 1'b1; w_re = 1'b1; w_opr1 = w_src1; w_opr2 = w_imm_i;
                w_ldu = w_f3[2]; w_rlen = f3_size(w_f3[1:0]);
                w_ill = (w_f3 == 3'd7) || (XLEN != 64 && (w_f3 == 3'd3 || w_f3 == 3'd6));
            end
            OPC_STORE: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_we = 1'b1; w_opr1 = w_src1; w_opr2 = w_imm_s;
                w_val = w_src2; w_wlen = f3_size(w_f3[1:0]);
                w_ill = w_f3[2] || (XLEN != 64 && w_f3 == 3'd3);
            end
            OPC_BRANCH: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_opr1 = w_src1; w_opr2 = w_src2;
                w_val = in_pc + w_imm_b; w_brinv = w_f3[0];
                case (w_f3[2:1])
                    2'b00:   w_alu = ALU_SEQ;
                    2'b10:   w_alu = ALU_SLT;
                    2'b11:   w_alu = ALU_SLTU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_MISC_MEM: w_ill = (w_f3[2:1] != 2'b00);
            default:      w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_re = 1'b0; w_we = 1'b0; w_writes = 1'b0;
        end
    end

    assign w_reg_we = w_writes && (w_rd != 5'd0);
    assign w_hazard = (w_use1 && w_busy1) || (w_use2 && w_busy2) || (w_reg_we && w_busyd);
    assign in_ready = !rst && !flush && !w_hazard && (r_state == SLOT_EMPTY || o_slot.out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (flush)                 w_state_nxt = SLOT_EMPTY;
        else if (w_accept)         w_state_nxt = SLOT_FULL;
        else if (o_slot.out_ready) w_state_nxt = SLOT_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= SLOT_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Set on accept beats clear from writeback or from flushing the held writer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst)
                r_busy[i] <= 1'b0;
            else if (w_accept && w_reg_we && w_rd == 5'(i))
                r_busy[i] <= 1'b1;
            else if ((wb_valid && wb_rd == 5'(i)) ||
                     (flush && r_state == SLOT_FULL && r_reg_we && r_rd == 5'(i)))
                r_busy[i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= '0; r_alu <= ALU_ADD; r_rd <= '0; r_reg_we <= 1'b0;
            r_opr1 <= '0; r_opr2 <= '0; r_val <= '0; r_re <= 1'b0; r_we <= 1'b0;
            r_rlen <= '0; r_wlen <= '0; r_ldu <= 1'b0; r_brinv <= 1'b0; r_ill <= 1'b0;
        end else if (w_accept) begin
            r_op <= w_opc; r_alu <= w_alu; r_rd <= w_rd; r_reg_we <= w_reg_we;
            r_opr1 <= w_opr1; r_opr2 <= w_opr2; r_val <= w_val; r_re <= w_re; r_we <= w_we;
            r_rlen <= w_rlen; r_wlen <= w_wlen; r_ldu <= w_ldu; r_brinv <= w_brinv; r_ill <= w_ill;
        end
    end

    assign o_slot.out_valid   = (r_state == SLOT_FULL);
    assign o_slot.op          = r_op;
    assign o_slot.alu_op      = ALUOP_L'(r_alu);
    assign o_slot.rd          = r_rd;
    assign o_slot.reg_we      = r_reg_we;
    assign o_slot.opr1        = r_opr1;
    assign o_slot.opr2        = r_opr2;
    assign o_slot.val         = r_val;
    assign o_slot.re          = r_re;
    assign o_slot.we          = r_we;
    assign o_slot.rlen        = r_rlen;
    assign o_slot.wlen        = r_wlen;
    assign o_slot.ld_unsigned = r_ldu;
    assign o_slot.br_inv      = r_brinv;
    assign o_slot.illegal     = r_ill;
endmodule

// File: tb/tb_pipe_decode.sv
// Directed bench for pipe_decode: a 32-bit and a 64-bit instance share stimulus.
module tb_pipe_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] rs1_data = 32'h0, rs2_data = 32'h0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'h0;
    logic        flush = 1'b0;
    logic        ordy = 1'b1;
    logic        rdy32, rdy64;
    logic [4:0]  r1a, r2a, r1b, r2b;
    int          n_err = 0, n_chk = 0;

    pipe_decode_if #(.XLEN(32), .ALUOP_L(5)) bus32 ();
    pipe_decode_if #(.XLEN(64), .ALUOP_L(5)) bus64 ();
    assign bus32.out_ready = ordy;
    assign bus64.out_ready = ordy;

    pipe_decode #(.XLEN(32), .ALUOP_L(5), .NREG(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
        .in_pc(in_pc), .rs1_idx(r1a), .rs2_idx(r2a), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .o_slot(bus32));

    pipe_decode #(.XLEN(64), .ALUOP_L(5), .NREG(32)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
        .in_pc({32'h0, in_pc}), .rs1_idx(r1b), .rs2_idx(r2b), .rs1_data({32'h0, rs1_data}),
        .rs2_data({32'h0, rs2_data}), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data({32'h0, wb_data}), .flush(flush), .o_slot(bus64));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; ordy = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_in_ready", rdy32, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus32.out_valid, 1'b0);
        check("rst_opr1", bus32.opr1, 0);
        check("rst_op", bus32.op, 0);
        check("idle_in_ready", rdy32, 1'b1);

        // ADDI x1,x0,5 ; ADD x2,x1,x1 stalls until x1 retires
        in_valid = 1'b1; in_inst = 32'h00500093; rs1_data = 32'h11111111;
        #1 check("addi_ready", rdy32, 1'b1);
        tick();
        check("addi_valid", bus32.out_valid, 1'b1);
        check("addi_op", bus32.op, 7'h13);
        check("addi_rd", bus32.rd, 5'd1);
        check("addi_we", bus32.reg_we, 1'b1);
        check("addi_opr1", bus32.opr1, 0);
        check("addi_opr2", bus32.opr2, 5);
        in_inst = 32'h00108133; rs1_data = 32'h00000BAD; rs2_data = 32'h00000BAD;
        #1 check("raw_stall0", rdy32, 1'b0);
        tick();
        check("raw_drained", bus32.out_valid, 1'b0);
        check("raw_stall1", rdy32, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        #1 check("raw_release", rdy32, 1'b1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        check("add_valid", bus32.out_valid, 1'b1);
        check("add_opr1_byp", bus32.opr1, 5);
        check("add_opr2_byp", bus32.opr2, 5);
        check("add_rd", bus32.rd, 5'd2);
        check("add_alu", bus32.alu_op, 5'd0);

        // Back-to-back: BGEU, SRAI, LUI, JAL
        do_reset();
        in_valid = 1'b1; in_inst = 32'hFE41FCE3; in_pc = 32'h100;
        rs1_data = 32'd7; rs2_data = 32'd9;
        #1 check("bgeu_rs1_idx", r1a, 5'd3);
        check("bgeu_rs2_idx", r2a, 5'd4);
        tick();
        check("bgeu_alu_sltu", bus32.alu_op, 5'd4);
        check("bgeu_br_inv", bus32.br_inv, 1'b1);
        check("bgeu_val", bus32.val, 32'hF8);
        check("bgeu_opr1", bus32.opr1, 7);
        check("bgeu_opr2", bus32.opr2, 9);
        check("bgeu_reg_we", bus32.reg_we, 1'b0);
        in_inst = 32'h4037D713; rs1_data = 32'h80000000;
        #1 check("srai_ready", rdy32, 1'b1);
        tick();
        check("srai_alu_sra", bus32.alu_op, 5'd7);
        check("srai_shamt", bus32.opr2, 3);
        check("srai_opr1", bus32.opr1, 32'h80000000);
        check("srai_illegal", bus32.illegal, 1'b0);
        in_inst = 32'h12345837;
        tick();
        check("lui_opr1", bus32.opr1, 0);
        check("lui_opr2", bus32.opr2, 32'h12345000);
        check("lui_rd", bus32.rd, 5'd16);
        in_inst = 32'h010000EF; in_pc = 32'h200;
        tick();
        in_valid = 1'b0;
        check("jal_opr1", bus32.opr1, 32'h200);
        check("jal_opr2", bus32.opr2, 4);
        check("jal_val", bus32.val, 32'h210);

        // LW x6 then flush while held; reader of x6 must issue freely
        do_reset();
        in_valid = 1'b1; in_inst = 32'h0083A303; rs1_data = 32'h1000;
        tick();
        ordy = 1'b0;
        check("lw_re", bus32.re, 1'b1);
        check("lw_rlen", bus32.rlen, 2'b11);
        check("lw_opr2", bus32.opr2, 8);
        in_inst = 32'h00630433; flush = 1'b1;
        #1 check("flush_in_ready", rdy32, 1'b0);
        tick();
        flush = 1'b0; ordy = 1'b1;
        check("flush_out_valid", bus32.out_valid, 1'b0);
        #1 check("flush_busy_clr", rdy32, 1'b1);
        tick();
        in_valid = 1'b0;
        check("post_flush_valid", bus32.out_valid, 1'b1);
        check("post_flush_rd", bus32.rd, 5'd8);

        // Writeback and accept of the same rd: busy must stay set
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00100293;
        tick();
        in_inst = 32'h00200293; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
        #1 check("waw_masked_ready", rdy32, 1'b1);
        tick();
        wb_valid = 1'b0;
        check("waw_opr2", bus32.opr2, 2);
        in_inst = 32'h000284B3; rs1_data = 32'h0BAD;
        #1 check("busy5_kept", rdy32, 1'b0);
        wb_valid = 1'b1; wb_data = 32'h99;
        #1 check("busy5_release", rdy32, 1'b1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        check("x9_opr1_byp", bus32.opr1, 32'h99);
        check("x9_opr2_x0", bus32.opr2, 0);

        // Held slot stays stable under backpressure; reset clears it
        do_reset();
        ordy = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093;
        tick();
        in_inst = 32'h00700193;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", rdy32, 1'b0);
            tick();
            check("bp_valid", bus32.out_valid, 1'b1);
            check("bp_opr2", bus32.opr2, 5);
            check("bp_rd", bus32.rd, 5'd1);
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; ordy = 1'b1;
        check("bp_rst_valid", bus32.out_valid, 1'b0);
        check("bp_rst_rd", bus32.rd, 5'd0);
        check("bp_rst_opr2", bus32.opr2, 0);

        // LD x10 / SD x12: legal only on the 64-bit instance
        do_reset();
        in_valid = 1'b1; in_inst = 32'h0005B503; rs1_data = 32'h40; rs2_data = 32'h1234;
        tick();
        check("ld32_illegal", bus32.illegal, 1'b1);
        check("ld32_re", bus32.re, 1'b0);
        check("ld32_reg_we", bus32.reg_we, 1'b0);
        check("ld64_illegal", bus64.illegal, 1'b0);
        check("ld64_re", bus64.re, 1'b1);
        check("ld64_rlen", bus64.rlen, 2'b10);
        check("ld64_reg_we", bus64.reg_we, 1'b1);
        in_inst = 32'h00C6B023;
        tick();
        in_valid = 1'b0;
        check("sd32_illegal", bus32.illegal, 1'b1);
        check("sd32_we", bus32.we, 1'b0);
        check("sd64_we", bus64.we, 1'b1);
        check("sd64_wlen", bus64.wlen, 2'b10);
        check("sd64_val", bus64.val, 64'h1234);
        check("sd64_illegal", bus64.illegal, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
